// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg                                                                   |
// | Shared widths, segment pattern constants and capture FSM state encoding.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    // Segment order {a,b,c,d,e,f,g}, a in bit 6, active-high after polarity fix.
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_to_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_to_bcd                                                                |
// | Combinational inverse 7-segment decode: pattern -> {legal, bcd}.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             legal,
    output logic [BCD_W-1:0] bcd
);

    always_comb begin
        legal = 1'b1;
        bcd   = 4'd0;
        case (pattern)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_capture                                                               |
// | Recovers per-position BCD digits from a multiplexed 7-segment bus.         |
// | Define SEG7_CAPTURE_SYNC_EN to add two-flop input synchronisers.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [DIGITS-1:0]       dig_sel,
    input  logic                    sel,
    input  logic                    err_clr,
    output logic [BCD_W*DIGITS-1:0] digit_out,
    output logic [DIGITS-1:0]       digit_valid,
    output logic                    upd,
    output logic                    err
);

    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam int               RAW_W   = 1 + DIGITS + SEG_W;

    logic [RAW_W-1:0]  raw_in;
    logic [RAW_W-1:0]  samp_raw;
    logic              samp_inv;
    logic [DIGITS-1:0] samp_sel;
    logic [SEG_W-1:0]  samp_seg;
    logic [SEG_W-1:0]  samp_pat;
    logic              samp_onehot;
    logic              samp_same;

    assign raw_in = {sel, dig_sel, seg_in};

`ifdef SEG7_CAPTURE_SYNC_EN
    logic [RAW_W-1:0] sync1_d, sync1_q;
    logic [RAW_W-1:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign samp_raw = sync2_q;
`else
    assign samp_raw = raw_in;
`endif

    assign samp_inv = samp_raw[RAW_W-1];
    assign samp_sel = samp_raw[SEG_W +: DIGITS];
    assign samp_seg = samp_raw[SEG_W-1:0];
    assign samp_pat = samp_inv ? ~samp_seg : samp_seg;

    logic [SEG_W-1:0]  prev_pat_d, prev_pat_q;
    logic [DIGITS-1:0] prev_sel_d, prev_sel_q;
    cap_state_t        state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              commit;

    assign samp_onehot = (samp_sel != '0) &&
                         ((samp_sel & (samp_sel - DIGITS'(1))) == '0);
    assign samp_same   = (samp_pat == prev_pat_q) && (samp_sel == prev_sel_q);

    always_comb begin
        prev_pat_d = samp_pat;
        prev_sel_d = samp_sel;
        state_d    = state_q;
        cnt_d      = cnt_q;
        commit     = 1'b0;
        case (state_q)
            BLANK: begin
                if (samp_onehot) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            TRACK: begin
                // The commit uses the stored sample, so it fires even if the
                // current sample has already moved on.
                commit = (cnt_q == CNT_MAX);
                if (samp_same && (cnt_q == CNT_MAX)) begin
                    state_d = HELD;
                end else if (samp_same) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (samp_onehot) begin
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (!samp_same) begin
                    if (samp_onehot) begin
                        state_d = TRACK;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    logic             dec_legal;
    logic [BCD_W-1:0] dec_bcd;

    seg7_to_bcd u_dec (
        .pattern (prev_pat_q),
        .legal   (dec_legal),
        .bcd     (dec_bcd)
    );

    logic [BCD_W*DIGITS-1:0] digit_d, digit_q;
    logic [DIGITS-1:0]       valid_d, valid_q;
    logic                    upd_d, upd_q;
    logic                    err_d, err_q;

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (commit && prev_sel_q[i]) begin
                if (dec_legal) begin
                    digit_d[i*BCD_W +: BCD_W] = dec_bcd;
                    valid_d[i]                = 1'b1;
                end else begin
                    valid_d[i]                = 1'b0;
                end
            end
        end
        upd_d = (digit_d != digit_q) || (valid_d != valid_q);
        // A new illegal commit outranks a coincident clear.
        err_d = (err_q && !err_clr) || (commit && !dec_legal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pat_q <= '0;
            prev_sel_q <= '0;
            state_q    <= BLANK;
            cnt_q      <= '0;
            digit_q    <= '0;
            valid_q    <= '0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_pat_q <= prev_pat_d;
            prev_sel_q <= prev_sel_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign upd         = upd_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_capture                                                            |
// | Directed bench for seg7_capture with a run-length reference model.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_seg7_capture;

    localparam int DIGITS = 4;
    localparam int S      = 4;
`ifdef SEG7_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [6:0]  seg_in  = '0;
    logic [3:0]  dig_sel = '0;
    logic        sel     = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] digit_out;
    logic [3:0]  digit_valid;
    logic        upd;
    logic        err;

    always #5 clk = ~clk;

    seg7_capture #(.DIGITS(DIGITS), .STABLE_CNT(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .sel         (sel),
        .err_clr     (err_clr),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .upd         (upd),
        .err         (err)
    );

    int n_vec     = 0;
    int n_bad     = 0;
    int upd_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a digit is committed exactly when a run of identical
    // one-hot samples reaches S entries; the sample stream lags the pins by LAT.
    logic [6:0]  legal_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                    7'b1111111, 7'b1111011};
    logic [10:0] pipe [2];
    logic [10:0] hist [$];
    logic [15:0] m_digit, m_nd;
    logic [3:0]  m_valid, m_nv;
    logic        m_upd, m_err;
    bit          m_ok = 0;
    logic [10:0] m_pins, m_cur, m_last;
    bit          m_commit, m_legal;
    int          m_pos, m_bcd;

    always @(posedge clk) begin
        m_pins = {dig_sel, sel ? ~seg_in : seg_in};
        if (rst) begin
            m_digit = '0; m_valid = '0; m_upd = 1'b0; m_err = 1'b0; m_ok = 1;
            pipe[0] = '0; pipe[1] = '0;
            hist.delete();
            hist.push_back('0);
        end else begin
`ifdef SEG7_CAPTURE_SYNC_EN
            m_cur = pipe[1];
`else
            m_cur = m_pins;
`endif
            pipe[1] = pipe[0];
            pipe[0] = m_pins;
            m_commit = 0;
            if (hist.size() == S + 1) begin
                m_last   = hist[S];
                m_commit = ($countones(m_last[10:7]) == 1) && (hist[0] != hist[1]);
                for (int i = 1; i < S; i++)
                    if (hist[i] != m_last) m_commit = 0;
            end
            m_nd = m_digit; m_nv = m_valid; m_legal = 1;
            if (m_commit) begin
                m_pos = 0; m_bcd = -1;
                for (int i = 0; i < 4; i++) if (m_last[7+i]) m_pos = i;
                for (int k = 0; k < 10; k++) if (legal_pat[k] == m_last[6:0]) m_bcd = k;
                m_legal = (m_bcd >= 0);
                if (m_legal) begin
                    m_nd[m_pos*4 +: 4] = 4'(m_bcd);
                    m_nv[m_pos]        = 1'b1;
                end else begin
                    m_nv[m_pos]        = 1'b0;
                end
            end
            m_upd   = (m_nd != m_digit) || (m_nv != m_valid);
            m_err   = (m_err && !err_clr) || (m_commit && !m_legal);
            m_digit = m_nd;
            m_valid = m_nv;
            hist.push_back(m_cur);
            if (hist.size() > S + 1) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("digit_out",   32'(digit_out),   32'(m_digit));
            check("digit_valid", 32'(digit_valid), 32'(m_valid));
            check("upd",         32'(upd),         32'(m_upd));
            check("err",         32'(err),         32'(m_err));
            if (upd === 1'b1) upd_total++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic [3:0] d, input logic [6:0] p);
        sel = s; dig_sel = d; seg_in = p;
    endtask

    int u0;

    initial begin
        rst = 1'b1;
        tick(2);
        check("reset_digit", 32'(digit_out), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_upd",   32'(upd), 32'h0);
        check("reset_err",   32'(err), 32'h0);
        rst = 1'b0;

        // Digit 2 on position 0, active-high
        drive(1'b0, 4'b0001, 7'b1101101);
        u0 = upd_total;
        tick(LAT + S);
        check("pos0_early_valid", 32'(digit_valid), 32'h0);
        tick(1);
        check("pos0_digit", 32'(digit_out[3:0]), 32'd2);
        check("pos0_valid", 32'(digit_valid), 32'b0001);
        tick(5);
        check("pos0_upd_pulses", 32'(upd_total - u0), 32'd1);

        // Digit 5 on position 2, active-low
        drive(1'b1, 4'b0100, 7'b0100100);
        tick(LAT + S + 1);
        check("pos2_digit", 32'(digit_out[11:8]), 32'd5);
        check("pos2_valid", 32'(digit_valid), 32'b0101);
        check("pos2_slot0_kept", 32'(digit_out[3:0]), 32'd2);
        tick(2);

        // Short dwell, then multi-hot strobe: nothing commits
        drive(1'b0, 4'b0010, 7'b1111001);
        u0 = upd_total;
        tick(3);
        drive(1'b0, 4'b0011, 7'b1111001);
        tick(20);
        check("short_valid", 32'(digit_valid), 32'b0101);
        check("short_digit1", 32'(digit_out[7:4]), 32'd0);
        check("short_upd", 32'(upd_total - u0), 32'd0);

        // Digit 3 on position 1
        drive(1'b0, 4'b0010, 7'b1111001);
        tick(LAT + S + 3);
        check("pos1_digit", 32'(digit_out[7:4]), 32'd3);
        check("pos1_valid", 32'(digit_valid), 32'b0111);

        // Illegal pattern on position 1
        drive(1'b0, 4'b0010, 7'b1000001);
        u0 = upd_total;
        tick(LAT + S + 3);
        check("illegal_digit_kept", 32'(digit_out[7:4]), 32'd3);
        check("illegal_valid", 32'(digit_valid), 32'b0101);
        check("illegal_err", 32'(err), 32'h1);
        check("illegal_upd_pulses", 32'(upd_total - u0), 32'd1);

        // Second illegal commit coincident with err_clr keeps err set
        drive(1'b0, 4'b0000, 7'b1000001);
        tick(3);
        drive(1'b0, 4'b0010, 7'b1000001);
        tick(LAT + S);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr_vs_set_err", 32'(err), 32'h1);
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr_alone_err", 32'(err), 32'h0);

        // Reset mid-dwell on position 3
        drive(1'b0, 4'b1000, 7'b1110000);
        tick(LAT + 3);
        rst = 1'b1;
        tick(1);
        check("midreset_digit", 32'(digit_out), 32'h0);
        check("midreset_valid", 32'(digit_valid), 32'h0);
        check("midreset_err",   32'(err), 32'h0);
        rst = 1'b0;
        tick(LAT + S);
        check("postreset_early_valid", 32'(digit_valid), 32'h0);
        tick(1);
        check("postreset_digit", 32'(digit_out[15:12]), 32'd7);
        check("postreset_valid", 32'(digit_valid), 32'b1000);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
